cut_injection_sequencer: RTL and testbench
==========================================

CUT_INJECTION_SEQUENCER -- requirements
Module: cut_injection_sequencer

Interface
REQ-001 SHALL have parameter TEST_W, default 19, test vector width.
REQ-002 SHALL have parameter RESULT_W, default 19, result vector width.
REQ-003 SHALL have parameter INJ_W, default 346, injection vector width (1..4096).
REQ-004 SHALL have parameter WORD_W, default 32, host load word width; NW = ceil(INJ_W/WORD_W).
REQ-005 SHALL have parameter WIN_W, default 16, cycle counter and window field width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_word  in  WORD_W  injection mask word.
- cfg_valid  in  1  cfg_word valid.
- cfg_ready  out  1  word accepted when cfg_valid and cfg_ready are both high.
- cfg_last  in  1  final word of the mask.
- start  in  1  run request.
- inj_start  in  WIN_W  first injected run cycle.
- inj_len  in  WIN_W  number of injected cycles.
- run_len  in  WIN_W  run length in cycles.
- test_in  in  TEST_W  stimulus.
- golden_in  in  RESULT_W  expected CUT result.
- result_in  in  RESULT_W  CUT result.
- test_out  out  TEST_W  stimulus to CUT.
- injection_out  out  INJ_W  fault enables to CUT.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.
- mismatch_out  out  1  result mismatch flag.
- err_count  out  16  mismatch count.

Function
REQ-007 SHALL implement states IDLE, LOAD, ARMED, RUN, DONE.
REQ-008 cfg_ready SHALL be high in IDLE, LOAD, ARMED and DONE, and low in RUN.
REQ-009 A word accepted in IDLE, ARMED or DONE SHALL clear the shadow mask, write it to bits [WORD_W-1:0], and enter LOAD (or ARMED if it is also the last word).
REQ-010 The k-th accepted word (k from 0) SHALL write shadow bits [k*WORD_W +: WORD_W]; bits at or above INJ_W SHALL be discarded.
REQ-011 LOAD SHALL go to ARMED on the cycle after accepting a word with cfg_last=1 or the NW-th word; unwritten bits SHALL stay 0.
REQ-012 start in ARMED or DONE SHALL enter RUN next cycle with cycle counter cyc=0, clearing err_count and mismatch_out; start in any other state SHALL be ignored.
REQ-013 In RUN, injection_out SHALL equal the shadow mask while inj_start <= cyc < inj_start+inj_len, and SHALL be 0 otherwise.
REQ-014 The window compare SHALL be evaluated at WIN_W+1 bits so the window never wraps; inj_len=0 SHALL give no injection.
REQ-015 injection_out and test_out SHALL be registered; test_out SHALL be test_in delayed by 1 cycle in every state.
REQ-016 Each RUN cycle SHALL compare result_in with golden_in; mismatch_out SHALL be asserted 1 cycle later and held until the next start.
REQ-017 RUN SHALL last exactly run_len cycles and then go to DONE; run_len=0 SHALL go directly from ARMED to DONE with no RUN cycle.
REQ-018 In DONE, injection_out SHALL be 0 and the shadow mask SHALL be retained for re-run.
REQ-019 Changes to inj_start, inj_len or run_len while in RUN SHALL have no effect; all three SHALL be captured at start.
REQ-020 If cfg_valid and start arrive in the same cycle in ARMED or DONE, start SHALL take priority and the word SHALL NOT be accepted (cfg_ready SHALL be low that cycle).

Reset
REQ-021 rst low SHALL asynchronously force state IDLE, and clear the shadow mask, counters, injection_out, test_out, mismatch_out, err_count and done.
REQ-022 Reset during RUN SHALL drop injection_out to 0 without waiting for clk.
REQ-023 After rst is released, the first clk edge SHALL be ordinary IDLE operation.

Configuration
REQ-024 With macro CUT_SEQ_ERRCNT_EN defined, err_count SHALL count RUN cycles with result_in != golden_in, saturating at 16'hFFFF, and SHALL be updated 1 cycle after each compare.
REQ-025 Without CUT_SEQ_ERRCNT_EN, err_count SHALL be tied to 0; all other behaviour, including mismatch_out, SHALL be unchanged.

Verification
REQ-026 INJ_W=346, WORD_W=32: load 11 words 0x00000001..0x0000000B, with cfg_last on the 11th -> ARMED; injection_out bit 320 =1 in the window; word 10 bits 26..31 discarded.
REQ-027 Load 2 words then cfg_last; inj_start=3, inj_len=2, run_len=8 -> injection_out nonzero only at cyc 3 and 4; done high after 8 RUN cycles.
REQ-028 result_in != golden_in on 3 RUN cycles -> mismatch_out=1 and err_count=3 (macro on); err_count=0 and mismatch_out=1 (macro off).
REQ-029 inj_start=0xFFFF, inj_len=0x0002, run_len=0xFFFF -> no wrap, and no injection at cyc 0.
REQ-030 rst pulsed low mid-RUN -> injection_out=0 within the same cycle, state IDLE, and a start afterwards is ignored until a mask is loaded.
REQ-031 start and cfg_valid in the same cycle in DONE -> RUN entered, word not accepted, mask unchanged.

Source files
------------

// File: rtl/cut_injection_sequencer.sv
// Fault-injection sequencer: loads a word-wise mask, then drives it onto the CUT
// during a cycle window of a timed run and flags result mismatches. Macro: CUT_SEQ_ERRCNT_EN.
module cut_injection_sequencer #(
    parameter int TEST_W   = 19,
    parameter int RESULT_W = 19,
    parameter int INJ_W    = 346,
    parameter int WORD_W   = 32,
    parameter int WIN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   cfg_word,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_last,
    input  logic                start,
    input  logic [WIN_W-1:0]    inj_start,
    input  logic [WIN_W-1:0]    inj_len,
    input  logic [WIN_W-1:0]    run_len,
    input  logic [TEST_W-1:0]   test_in,
    input  logic [RESULT_W-1:0] golden_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic [TEST_W-1:0]   test_out,
    output logic [INJ_W-1:0]    injection_out,
    output logic                busy,
    output logic                done,
    output logic                mismatch_out,
    output logic [15:0]         err_count
);

    localparam int NW = (INJ_W + WORD_W - 1) / WORD_W;
    localparam int IW = $clog2(NW + 1);
    localparam logic [IW-1:0] LASTW = IW'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [INJ_W-1:0]   shadow_q, shadow_d;
    logic [IW-1:0]      widx_q, widx_d;
    logic [WIN_W-1:0]   cyc_q, cyc_d;
    logic [WIN_W-1:0]   ist_q, ist_d;
    logic [WIN_W-1:0]   ilen_q, ilen_d;
    logic [WIN_W-1:0]   rlen_q, rlen_d;
    logic [INJ_W-1:0]   inj_q, inj_d;
    logic [TEST_W-1:0]  test_q;
    logic               mis_q;

    logic               start_ok;
    logic               accept;
    logic               load_word;
    logic               mis_now;
    logic               in_win;
    logic [IW-1:0]      wsel;
    logic [INJ_W-1:0]   wmask;
    logic [INJ_W-1:0]   wdata;
    logic [INJ_W-1:0]   base;

    assign start_ok  = start && (state_q == S_ARMED || state_q == S_DONE);
    assign cfg_ready = (state_q != S_RUN) && !start_ok;
    assign accept    = cfg_valid && cfg_ready;
    assign mis_now   = (result_in != golden_in);
    assign wsel      = (state_q == S_LOAD) ? widx_q : '0;
    assign base      = (state_q == S_LOAD) ? shadow_q : '0;

    // Per-bit word-slot decode; bits past INJ_W simply have no slot.
    for (genvar j = 0; j < INJ_W; j++) begin : g_bit
        assign wmask[j] = (wsel == IW'(j / WORD_W));
        assign wdata[j] = cfg_word[j % WORD_W];
    end

    // Window test in WIN_W+1 bits so start+len cannot wrap.
    assign in_win = ({1'b0, cyc_d} >= {1'b0, ist_d}) &&
                    ({1'b0, cyc_d} < ({1'b0, ist_d} + {1'b0, ilen_d}));

    // Next-state, mask load, run capture and next injection value.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        widx_d    = widx_q;
        cyc_d     = cyc_q;
        ist_d     = ist_q;
        ilen_d    = ilen_q;
        rlen_d    = rlen_q;
        load_word = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD: begin
                load_word = accept;
            end
            S_ARMED, S_DONE: begin
                if (start_ok) begin
                    ist_d   = inj_start;
                    ilen_d  = inj_len;
                    rlen_d  = run_len;
                    cyc_d   = '0;
                    state_d = (run_len == '0) ? S_DONE : S_RUN;
                end else begin
                    load_word = accept;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (({1'b0, cyc_q} + 1'b1) == {1'b0, rlen_q}) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load_word) begin
            shadow_d = (base & ~wmask) | (wdata & wmask);
            widx_d   = wsel + 1'b1;
            state_d  = (cfg_last || wsel == LASTW) ? S_ARMED : S_LOAD;
        end
        inj_d = (state_d == S_RUN && in_win) ? shadow_q : '0;
    end

    // Sequencer state, mask, run counters and registered CUT drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            widx_q   <= '0;
            cyc_q    <= '0;
            ist_q    <= '0;
            ilen_q   <= '0;
            rlen_q   <= '0;
            inj_q    <= '0;
            test_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            widx_q   <= widx_d;
            cyc_q    <= cyc_d;
            ist_q    <= ist_d;
            ilen_q   <= ilen_d;
            rlen_q   <= rlen_d;
            inj_q    <= inj_d;
            test_q   <= test_in;
        end
    end

    // Sticky mismatch flag, cleared when a new run starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else if (start_ok) begin
            mis_q <= 1'b0;
        end else if (state_q == S_RUN && mis_now) begin
            mis_q <= 1'b1;
        end
    end

`ifdef CUT_SEQ_ERRCNT_EN
    logic [15:0] err_q;

    // Saturating count of mismatching run cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else if (start_ok) begin
            err_q <= '0;
        end else if (state_q == S_RUN && mis_now && err_q != 16'hFFFF) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'h0000;
`endif

    assign test_out      = test_q;
    assign injection_out = inj_q;
    assign mismatch_out  = mis_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_cut_injection_sequencer.sv
// Bench for cut_injection_sequencer: directed runs checked every cycle
// against a transaction-level model, plus literal expectations.
module tb_cut_injection_sequencer;

    localparam int TEST_W   = 19;
    localparam int RESULT_W = 19;
    localparam int INJ_W    = 346;
    localparam int WORD_W   = 32;
    localparam int WIN_W    = 16;
    localparam int NW       = 11;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_ARMED = 2;
    localparam int P_RUN   = 3;
    localparam int P_DONE  = 4;

    logic                clk;
    logic                rst;
    logic [WORD_W-1:0]   cfg_word;
    logic                cfg_valid;
    logic                cfg_ready;
    logic                cfg_last;
    logic                start;
    logic [WIN_W-1:0]    inj_start;
    logic [WIN_W-1:0]    inj_len;
    logic [WIN_W-1:0]    run_len;
    logic [TEST_W-1:0]   test_in;
    logic [RESULT_W-1:0] golden_in;
    logic [RESULT_W-1:0] result_in;
    logic [TEST_W-1:0]   test_out;
    logic [INJ_W-1:0]    injection_out;
    logic                busy;
    logic                done;
    logic                mismatch_out;
    logic [15:0]         err_count;

    cut_injection_sequencer #(
        .TEST_W(TEST_W), .RESULT_W(RESULT_W), .INJ_W(INJ_W),
        .WORD_W(WORD_W), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_last(cfg_last),
        .start(start), .inj_start(inj_start),
        .inj_len(inj_len), .run_len(run_len),
        .test_in(test_in), .golden_in(golden_in),
        .result_in(result_in), .test_out(test_out),
        .injection_out(injection_out), .busy(busy),
        .done(done), .mismatch_out(mismatch_out),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk_v(input string nm, input logic [INJ_W-1:0] act,
                         input logic [INJ_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Model: the mask as a bit array, run parameters as plain integers.
    int               m_ph;
    int               m_k;
    int               m_cyc;
    int               m_s;
    int               m_l;
    int               m_rl;
    int               m_err;
    bit               m_mis;
    logic [INJ_W-1:0] m_mask;
    logic [TEST_W-1:0] m_test;

    function automatic logic [INJ_W-1:0] put_word(input logic [INJ_W-1:0] m,
                                                  input int k,
                                                  input logic [WORD_W-1:0] w);
        for (int j = 0; j < WORD_W; j++) begin
            if (k * WORD_W + j < INJ_W) m[k * WORD_W + j] = w[j];
        end
        return m;
    endfunction

    function automatic bit m_ready();
        if (m_ph == P_RUN) return 1'b0;
        if (start && (m_ph == P_ARMED || m_ph == P_DONE)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [INJ_W-1:0] m_inj();
        if (m_ph == P_RUN && m_cyc >= m_s && m_cyc < m_s + m_l) return m_mask;
        return '0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph   <= P_IDLE;
            m_k    <= 0;
            m_cyc  <= 0;
            m_s    <= 0;
            m_l    <= 0;
            m_rl   <= 0;
            m_err  <= 0;
            m_mis  <= 1'b0;
            m_mask <= '0;
            m_test <= '0;
        end else begin
            m_test <= test_in;
            if (start && (m_ph == P_ARMED || m_ph == P_DONE)) begin
                m_s   <= int'(inj_start);
                m_l   <= int'(inj_len);
                m_rl  <= int'(run_len);
                m_cyc <= 0;
                m_err <= 0;
                m_mis <= 1'b0;
                m_ph  <= (run_len == 0) ? P_DONE : P_RUN;
            end else if (m_ph == P_RUN) begin
                if (result_in != golden_in) begin
                    m_mis <= 1'b1;
                    if (m_err < 65535) m_err <= m_err + 1;
                end
                m_cyc <= m_cyc + 1;
                if (m_cyc + 1 == m_rl) m_ph <= P_DONE;
            end else if (cfg_valid && m_ready()) begin
                m_mask <= put_word((m_ph == P_LOAD) ? m_mask : '0,
                                   (m_ph == P_LOAD) ? m_k : 0, cfg_word);
                m_k    <= ((m_ph == P_LOAD) ? m_k : 0) + 1;
                m_ph   <= (cfg_last || ((m_ph == P_LOAD) ? m_k : 0) + 1 == NW)
                          ? P_ARMED : P_LOAD;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk_v("injection_out", injection_out, m_inj());
        chk_i("test_out", int'(test_out), int'(m_test));
        chk_i("cfg_ready", int'(cfg_ready), int'(m_ready()));
        chk_i("busy", int'(busy), int'(m_ph == P_LOAD || m_ph == P_RUN));
        chk_i("done", int'(done), int'(m_ph == P_DONE));
        chk_i("mismatch_out", int'(mismatch_out), int'(m_mis));
`ifdef CUT_SEQ_ERRCNT_EN
        chk_i("err_count", int'(err_count), m_err);
`else
        chk_i("err_count", int'(err_count), 0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [WORD_W-1:0] w, input bit last);
        cfg_word  = w;
        cfg_last  = last;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic start_run(input int s, input int l, input int rl);
        inj_start = WIN_W'(s);
        inj_len   = WIN_W'(l);
        run_len   = WIN_W'(rl);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] pat, output int n,
                             output int nz, output int first);
        logic [RESULT_W-1:0] one;
        one   = 1;
        n     = 0;
        nz    = 0;
        first = -1;
        while (!done && n < 200) begin
            if (injection_out != '0) begin
                nz++;
                if (first < 0) first = n;
            end
            test_in   = TEST_W'($urandom);
            result_in = RESULT_W'($urandom);
            golden_in = result_in;
            if (n < 32 && pat[n]) golden_in = result_in ^ one;
            n++;
            tick();
        end
        golden_in = result_in;
        chk_i("run_end_timeout", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nz, first;
        rst = 1'b0;
        cfg_word = '0; cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
        inj_start = '0; inj_len = '0; run_len = '0;
        test_in = '0; golden_in = '0; result_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_i("reset_inj", int'(injection_out != '0), 0);
        chk_i("reset_done", int'(done), 0);
        chk_i("reset_err", int'(err_count), 0);
        chk_i("reset_ready", int'(cfg_ready), 1);
        rst = 1'b1;
        tick();

        start_run(0, 4, 4);
        chk_i("idle_start_ignored", int'(busy || done), 0);

        for (int i = 1; i <= 11; i++) load_word(WORD_W'(i), i == 11);
        chk_i("armed_after_last", int'(busy || done), 0);
        start_run(0, 4, 6);
        chk_i("bit320", int'(injection_out[320]), 1);
        chk_i("word10_trunc", int'(injection_out[345:320]), 11);
        chk_i("word0", int'(injection_out[31:0]), 1);
        chk_i("word1", int'(injection_out[63:32]), 2);
        wait_done(32'h0, n, nz, first);
        chk_i("t1_len", n, 6);

        for (int i = 0; i < 11; i++) load_word(WORD_W'(i * 7 + 3), 1'b0);
        chk_i("nw_word_arms", int'(busy), 0);

        load_word(32'hDEADBEEF, 1'b0);
        load_word(32'h12345678, 1'b1);
        start_run(3, 2, 8);
        inj_start = '0;
        inj_len   = 16'd100;
        run_len   = 16'd2;
        wait_done(32'h0, n, nz, first);
        chk_i("t2_run_cycles", n, 8);
        chk_i("t2_inj_cycles", nz, 2);
        chk_i("t2_inj_first", first, 3);

        start_run(0, 0, 10);
        wait_done(32'h92, n, nz, first);
        chk_i("t3_run_cycles", n, 10);
        chk_i("t3_mismatch", int'(mismatch_out), 1);
`ifdef CUT_SEQ_ERRCNT_EN
        chk_i("t3_err_count", int'(err_count), 3);
`else
        chk_i("t3_err_count", int'(err_count), 0);
`endif

        start_run(16'hFFFF, 2, 20);
        chk_i("t4_no_inj_cyc0", int'(injection_out != '0), 0);
        wait_done(32'h0, n, nz, first);
        chk_i("t4_inj_cycles", nz, 0);
        chk_i("t4_run_cycles", n, 20);

        inj_start = '0;
        inj_len   = 16'd3;
        run_len   = 16'd3;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_last  = 1'b1;
        cfg_word  = 32'hFFFFFFFF;
        #1;
        chk_i("t5_ready_low", int'(cfg_ready), 0);
        tick();
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        chk_i("t5_run", int'(busy), 1);
        chk_i("t5_mask_lo", int'(injection_out[31:0]), int'(32'hDEADBEEF));
        chk_i("t5_mask_hi", int'(injection_out[63:32]), int'(32'h12345678));
        wait_done(32'h0, n, nz, first);

        start_run(0, 1, 0);
        chk_i("zero_len_done", int'(done), 1);

        start_run(0, 20, 20);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk_i("rst_inj_now", int'(injection_out != '0), 0);
        chk_i("rst_idle", int'(busy || done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start_run(0, 5, 5);
        chk_i("rst_start_ignored", int'(busy || done), 0);
        load_word(32'h5, 1'b1);
        start_run(0, 2, 3);
        wait_done(32'h0, n, nz, first);
        chk_i("recover_run", n, 3);
        chk_i("recover_inj", nz, 2);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
